// File: rtl/switch_input_port_if.sv
// Picoblaze-side port bus of the switch conditioning stage: address/strobe/ack
// in, registered read data and interrupt request out.
interface switch_input_port_if;
  logic [7:0] PORT_ID;
  logic       READ_STROBE;
  logic       INTERRUPT_ACK;
  logic [7:0] IN_PORT_DATA;
  logic       INTERRUPT;

  modport master (
    output PORT_ID, READ_STROBE, INTERRUPT_ACK,
    input  IN_PORT_DATA, INTERRUPT
  );

  modport slave (
    input  PORT_ID, READ_STROBE, INTERRUPT_ACK,
    output IN_PORT_DATA, INTERRUPT
  );
endinterface

// File: rtl/switch_input_port.sv
// Board switch conditioning: 2-flop sync, per-bit debounce, sticky change flags,
// change interrupt and a registered two-port read mux for the Picoblaze.
module switch_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 24,
  parameter logic [7:0]  STATE_PORT      = 8'h00,
  parameter logic [7:0]  CHANGE_PORT     = 8'h01
) (
  input  logic               CLK_IN,
  input  logic               RESET_IN,
  input  logic [7:0]         SWITCHES,
  output logic [7:0]         SWITCH_STATE,
  switch_input_port_if.slave pb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1_q, sync1_d;
  logic [7:0]       sync2_q, sync2_d;
  logic [7:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [7:0]       flags_q, flags_d;
  logic             irq_q, irq_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic [7:0]       change_evt;
  logic             flag_clr;

  always_comb begin
    sync1_d    = SWITCHES;
    sync2_d    = sync1_q;
    state_d    = state_q;
    change_evt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      // Count only while the synchronised level disagrees with the debounced one
      if (sync2_q[i] != state_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          state_d[i]    = sync2_q[i];
          change_evt[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    // An event on the clearing edge wins for its own bit
    flag_clr = pb.READ_STROBE && (pb.PORT_ID == CHANGE_PORT);
    flags_d  = (flag_clr ? 8'h00 : flags_q) | change_evt;
    irq_d    = (|change_evt) | (irq_q & ~pb.INTERRUPT_ACK);

    if (pb.PORT_ID == STATE_PORT) begin
      rd_data_d = state_q;
    end else if (pb.PORT_ID == CHANGE_PORT) begin
      rd_data_d = flags_q;
    end else begin
      rd_data_d = 8'h00;
    end
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= '0;
      flags_q   <= '0;
      irq_q     <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      flags_q   <= flags_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign SWITCH_STATE    = state_q;
  assign pb.IN_PORT_DATA = rd_data_q;
  assign pb.INTERRUPT    = irq_q;

endmodule
